// File: rtl/fpu_pkg.sv
// fpu_pkg: shared IEEE-754 single-precision field constants, type and NaN helper.
package fpu_pkg;
   localparam int FP32_W  = 32;
   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;
   localparam int MAN_MSB = 22;
   typedef logic [FP32_W-1:0] fp32_t;
   // NaN: all-ones exponent with any nonzero mantissa bit (infinity has mantissa 0)
   function automatic logic is_nan(input fp32_t v);
      return (&v[EXP_MSB:EXP_LSB]) && (|v[MAN_MSB:0]);
   endfunction
endpackage

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: flop-based synchronous FIFO with a registered head output.
// Ports: clk/rst (async, active-high); push/wdata write side; pop request
// (ignored when empty); rdata/valid registered head; count and count_next
// occupancy; full/empty status; drop flags a push lost to a full FIFO.
module fpu_sync_fifo
   import fpu_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          valid,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_next,
   output logic          full,
   output logic          empty,
   output logic          drop
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic          do_push;
   logic          do_pop;
   assign empty      = count == '0;
   assign full       = count == CW'(DEPTH);
   assign do_pop     = pop & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign do_push    = push & (~full | do_pop);
   assign drop       = push & ~do_push;
   assign rd_next    = rd_ptr + AW'(do_pop);
   assign count_next = count + CW'(do_push) - CW'(do_pop);
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;
   // head is registered from next-state pointers; a write landing on the new
   // head slot this cycle is forwarded so an empty FIFO shows data one cycle later
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         rdata  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_next;
         count  <= count_next;
         valid  <= count_next != '0;
         if (count_next != '0) rdata <= (do_push && wr_ptr == rd_next) ? wdata : mem[rd_next];
      end
endmodule

// File: rtl/fpu_result_collector.sv
// fpu_result_collector: buffers the no-backpressure multiplier result stream
// and re-presents it on valid/ready, tracking credits for the upstream issuer.
// Ports: aclk, areset (async, active-high); issue pulse and registered
// issue_ok credit; s_valid/s_data result input; m_valid/m_data/m_ready output;
// count (FIFO occupancy), inflight (issued, not yet returned), sticky overflow.
// Optional: define FPU_NAN_FLAG_EN to add the sticky nan_seen output.
module fpu_result_collector
   import fpu_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 16,
   parameter int MAX_INFLIGHT = 16,
   localparam int CW          = $clog2(DEPTH) + 1,
   localparam int IW          = $clog2(MAX_INFLIGHT) + 1
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              issue,
   output logic              issue_ok,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [CW-1:0]     count,
   output logic [IW-1:0]     inflight,
   output logic              overflow
`ifdef FPU_NAN_FLAG_EN
   ,output logic             nan_seen
`endif
);
   logic [CW-1:0] count_next;
   logic [IW-1:0] inflight_next;
   logic          full;
   logic          empty;
   logic          drop;
   logic          inc;
   logic          dec;
   logic          at_max;
   logic          at_zero;
   logic          err;
   fpu_sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk        (aclk),
      .rst        (areset),
      .push       (s_valid),
      .wdata      (s_data),
      .pop        (m_ready),
      .rdata      (m_data),
      .valid      (m_valid),
      .count      (count),
      .count_next (count_next),
      .full       (full),
      .empty      (empty),
      .drop       (drop)
   );
   // a result returning in the same cycle as a new issue leaves the count unchanged
   assign inc     = issue & ~s_valid;
   assign dec     = s_valid & ~issue;
   assign at_max  = inflight == IW'(MAX_INFLIGHT);
   assign at_zero = inflight == '0;
   assign inflight_next = (inc && !at_max) ? inflight + IW'(1) :
                          (dec && !at_zero) ? inflight - IW'(1) : inflight;
   assign err = (inc & at_max) | (dec & at_zero) | drop;
   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         inflight <= '0;
         overflow <= 1'b0;
         issue_ok <= 1'b1;
      end else begin
         inflight <= inflight_next;
         overflow <= overflow | err;
         issue_ok <= (32'(count_next) + 32'(inflight_next)) < 32'(DEPTH);
      end
`ifdef FPU_NAN_FLAG_EN
   always_ff @(posedge aclk or posedge areset)
      if (areset) nan_seen <= 1'b0;
      else if (s_valid && is_nan(fp32_t'(s_data[FP32_W-1:0]))) nan_seen <= 1'b1;
`endif
endmodule

// File: tb/tb_fpu_result_collector.sv
// tb_fpu_result_collector: directed self-checking bench for fpu_result_collector (DEPTH=4).
module tb_fpu_result_collector;
   localparam int DEPTH = 4;
   localparam int MAXI  = 16;
   logic        aclk = 0;
   logic        areset = 1;
   logic        issue = 0;
   logic        issue_ok;
   logic        s_valid = 0;
   logic [31:0] s_data = '0;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready = 0;
   logic [2:0]  count;
   logic [4:0]  inflight;
   logic        overflow;
`ifdef FPU_NAN_FLAG_EN
   logic        nan_seen;
`endif
   int checks = 0;
   int errors = 0;
   fpu_result_collector #(.DATA_W(32), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
      .aclk     (aclk),
      .areset   (areset),
      .issue    (issue),
      .issue_ok (issue_ok),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_ready  (m_ready),
      .count    (count),
      .inflight (inflight),
      .overflow (overflow)
`ifdef FPU_NAN_FLAG_EN
      ,.nan_seen (nan_seen)
`endif
   );
   always #5 aclk = ~aclk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic i, input logic v, input logic [31:0] d, input logic r);
      issue = i;
      s_valid = v;
      s_data = d;
      m_ready = r;
      @(posedge aclk);
      #1;
   endtask
   task automatic do_reset();
      issue = 0;
      s_valid = 0;
      m_ready = 0;
      areset = 1;
      @(posedge aclk);
      #1;
      areset = 0;
   endtask
   initial begin
      repeat (2) @(posedge aclk);
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_count", count, 0);
      check("rst_inflight", inflight, 0);
      check("rst_issue_ok", issue_ok, 1);
      check("rst_overflow", overflow, 0);
      areset = 0;
      // single pass
      step(1, 0, 0, 1);
      check("sp_inflight", inflight, 1);
      step(0, 1, 32'h3FC00000, 1);
      check("sp_m_valid", m_valid, 1);
      check("sp_m_data", m_data, 32'h3FC00000);
      check("sp_inflight0", inflight, 0);
      step(0, 0, 0, 1);
      check("sp_count0", count, 0);
      check("sp_empty", m_valid, 0);
      check("sp_hold", m_data, 32'h3FC00000);
      check("sp_overflow", overflow, 0);
      // credit flow
      step(1, 0, 0, 0);
      check("cf_ok1", issue_ok, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      check("cf_inflight4", inflight, 4);
      check("cf_ok0", issue_ok, 0);
      step(0, 1, 32'h3F800000, 0);
      check("cf_first", m_data, 32'h3F800000);
      check("cf_first_v", m_valid, 1);
      step(0, 1, 32'h40000000, 0);
      step(0, 1, 32'h40400000, 0);
      step(0, 1, 32'h40800000, 0);
      check("cf_count4", count, 4);
      check("cf_inflight0", inflight, 0);
      check("cf_ok_full", issue_ok, 0);
      check("cf_hold", m_data, 32'h3F800000);
      // full push with simultaneous pop
      step(1, 1, 32'h40A00000, 1);
      check("fp_count", count, 4);
      check("fp_overflow", overflow, 0);
      check("fp_head", m_data, 32'h40000000);
      step(0, 0, 0, 1);
      check("dr_3", m_data, 32'h40400000);
      step(0, 0, 0, 1);
      check("dr_4", m_data, 32'h40800000);
      step(0, 0, 0, 1);
      check("dr_5_tail", m_data, 32'h40A00000);
      step(0, 0, 0, 1);
      check("dr_empty", m_valid, 0);
      check("dr_count", count, 0);
      check("dr_ok", issue_ok, 1);
      // overflow on full push without pop
      step(1, 1, 32'h41000000, 0);
      step(1, 1, 32'h41100000, 0);
      step(1, 1, 32'h41200000, 0);
      step(1, 1, 32'h41300000, 0);
      check("of_pre", overflow, 0);
      step(1, 1, 32'h41400000, 0);
      check("of_count", count, 4);
      check("of_set", overflow, 1);
      check("of_head", m_data, 32'h41000000);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      check("of_sticky", overflow, 1);
      // reset mid-stream with 3 queued and one in flight
      step(1, 0, 0, 1);
      check("mr_count3", count, 3);
      check("mr_inflight1", inflight, 1);
      do_reset();
      check("mr_m_valid", m_valid, 0);
      check("mr_count", count, 0);
      check("mr_inflight", inflight, 0);
      check("mr_ok", issue_ok, 1);
      check("mr_overflow", overflow, 0);
      // fresh result after reset, returning with nothing in flight
      step(0, 1, 32'h3F800000, 0);
      check("un_count", count, 1);
      check("un_data", m_data, 32'h3F800000);
      check("un_inflight", inflight, 0);
      check("un_overflow", overflow, 1);
      // in-flight saturation
      do_reset();
      for (int i = 0; i < MAXI; i++) step(1, 0, 0, 0);
      check("sat_max", inflight, MAXI);
      check("sat_pre", overflow, 0);
      step(1, 0, 0, 0);
      check("sat_hold", inflight, MAXI);
      check("sat_overflow", overflow, 1);
`ifdef FPU_NAN_FLAG_EN
      do_reset();
      step(1, 1, 32'h7F800000, 1);
      check("nan_inf", nan_seen, 0);
      step(1, 1, 32'h7FC00000, 1);
      check("nan_set", nan_seen, 1);
      step(0, 0, 0, 1);
      check("nan_sticky", nan_seen, 1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
